// File: rtl/ring_uart_tx.sv
// ring_uart_tx: drains a ring buffer read port onto an async serial line.
// Define TX_PARITY_EN to insert an even-parity bit after the data bits.
module ring_uart_tx #(
  parameter int WordSize     = 8,
  parameter int ClocksPerBit = 16,
  parameter int RetryDelay   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                txEnable,
  output logic                dataReadEnable,
  input  logic                dataReadAck,
  input  logic [WordSize-1:0] dataRead,
  output logic                txd,
  output logic                busy,
  output logic [15:0]         frameCount
);

  localparam int CntMax =
    (ClocksPerBit > RetryDelay) ? ClocksPerBit : RetryDelay;
  localparam int CW = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam int BW = (WordSize > 1) ? $clog2(WordSize) : 1;

  localparam logic [CW-1:0] BitLoad   = CW'(ClocksPerBit - 1);
  localparam logic [CW-1:0] RetryLoad = CW'(RetryDelay - 1);
  localparam logic [BW-1:0] BitsLoad  = BW'(WordSize - 1);

`ifdef TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, REQ, WAIT, BACKOFF, START, DATA, PARITY, STOP
  } state_t;
  localparam state_t AfterData = PARITY;
`else
  typedef enum logic [2:0] {
    IDLE, REQ, WAIT, BACKOFF, START, DATA, STOP
  } state_t;
  localparam state_t AfterData = STOP;
`endif

  state_t              state, state_n;
  logic [CW-1:0]       cnt;
  logic [BW-1:0]       bitcnt;
  logic [WordSize-1:0] shreg;
  logic                cnt_done;
`ifdef TX_PARITY_EN
  logic                par_q;
`endif

  assign cnt_done = (cnt == '0);

  always_comb begin
    state_n        = state;
    dataReadEnable = 1'b0;
    busy           = 1'b0;
    txd            = 1'b1;
    unique case (state)
      IDLE: begin
        if (txEnable) state_n = REQ;
      end
      REQ: begin
        dataReadEnable = 1'b1;
        busy           = 1'b1;
        state_n        = WAIT;
      end
      WAIT: begin
        busy    = 1'b1;
        state_n = dataReadAck ? START : BACKOFF;
      end
      BACKOFF: begin
        if (cnt_done) state_n = txEnable ? REQ : IDLE;
      end
      START: begin
        busy = 1'b1;
        txd  = 1'b0;
        if (cnt_done) state_n = DATA;
      end
      DATA: begin
        busy = 1'b1;
        txd  = shreg[0];
        if (cnt_done && bitcnt == '0) state_n = AfterData;
      end
`ifdef TX_PARITY_EN
      PARITY: begin
        busy = 1'b1;
        txd  = par_q;
        if (cnt_done) state_n = STOP;
      end
`endif
      STOP: begin
        busy = 1'b1;
        if (cnt_done) state_n = txEnable ? REQ : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Divider reloads on every state entry and at every bit boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      bitcnt     <= '0;
      shreg      <= '0;
      frameCount <= '0;
`ifdef TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state <= state_n;
      if (state_n != state || cnt_done)
        cnt <= (state_n == BACKOFF) ? RetryLoad : BitLoad;
      else
        cnt <= cnt - CW'(1);
      if (state_n == DATA && state != DATA)
        bitcnt <= BitsLoad;
      else if (state == DATA && cnt_done)
        bitcnt <= bitcnt - BW'(1);
      if (state == WAIT && dataReadAck) begin
        shreg <= dataRead;
`ifdef TX_PARITY_EN
        par_q <= ^dataRead;
`endif
      end else if (state == DATA && cnt_done) begin
        shreg <= shreg >> 1;
      end
      if (state == STOP && cnt_done)
        frameCount <= frameCount + 16'd1;
    end
  end

endmodule

// File: tb/tb_ring_uart_tx.sv
// tb_ring_uart_tx: buffer model, scoreboard of expected words,
// and a line monitor that decodes frames from txd.
module tb_ring_uart_tx;

  localparam int W   = 8;
  localparam int CPB = 4;
  localparam int RD  = 4;
`ifdef TX_PARITY_EN
  localparam int NB = W + 3;
`else
  localparam int NB = W + 2;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         txEnable = 1'b0;
  logic         dataReadAck = 1'b0;
  logic [W-1:0] dataRead = '0;
  logic         dataReadEnable;
  logic         txd;
  logic         busy;
  logic [15:0]  frameCount;

  int           errors = 0;
  int           checks = 0;
  int           cyc = 0;
  int           exp_fc = 0;
  bit           stale = 1'b0;
  logic [W-1:0] buf_q[$];
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  ring_uart_tx #(
    .WordSize(W),
    .ClocksPerBit(CPB),
    .RetryDelay(RD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .txEnable(txEnable),
    .dataReadEnable(dataReadEnable),
    .dataReadAck(dataReadAck),
    .dataRead(dataRead),
    .txd(txd),
    .busy(busy),
    .frameCount(frameCount)
  );

  task automatic chk(string name, logic [31:0] got,
                     logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  function automatic logic [31:0] st();
    return 32'({txd, dataReadEnable, busy, frameCount});
  endfunction

  task automatic wait_fc(int target, int budget, string name);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (32'(frameCount) == 32'(target)) break;
    end
    chk(name, 32'(frameCount), 32'(target));
  endtask

  task automatic wait_req(int budget, string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (dataReadEnable) begin
        seen = 1'b1;
        break;
      end
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  // Ring buffer model: answers a request one cycle later
  initial begin
    bit req;
    forever begin
      @(negedge clk);
      req = dataReadEnable;
      @(posedge clk);
      cyc++;
      if (req && buf_q.size() > 0) begin
        dataReadAck <= 1'b1;
        dataRead    <= buf_q.pop_front();
      end else if (req) begin
        dataReadAck <= 1'b0;
        dataRead    <= 8'hC3;
      end else begin
        dataReadAck <= stale;
        dataRead    <= stale ? 8'h5A : 8'h00;
      end
    end
  end

  // Monitor: decodes txd frames and pops the scoreboard
  initial begin
    bit           on;
    bit           stable;
    bit           fc_pend;
    int           pos;
    logic         b[0:15];
    logic [W-1:0] d;
    logic [W-1:0] e;
    on = 1'b0;
    stable = 1'b1;
    fc_pend = 1'b0;
    pos = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        on = 1'b0;
        fc_pend = 1'b0;
        exp_fc = 0;
        exp_q.delete();
      end else begin
        if (fc_pend) begin
          chk("frame_count", 32'(frameCount), 32'(exp_fc));
          fc_pend = 1'b0;
        end
        if (!on && txd == 1'b0) begin
          on = 1'b1;
          pos = 0;
          stable = 1'b1;
        end
        if (on) begin
          if (pos % CPB == 0) b[pos/CPB] = txd;
          else if (txd !== b[pos/CPB]) stable = 1'b0;
          pos++;
          if (pos == NB * CPB) begin
            on = 1'b0;
            for (int i = 0; i < W; i++) d[i] = b[i+1];
            chk("frame_shape", 32'({stable, b[0], b[NB-1]}),
                32'h5);
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL frame_unexpected: got %0h want none", d);
            end else begin
              e = exp_q.pop_front();
              chk("frame_data", 32'(d), 32'(e));
`ifdef TX_PARITY_EN
              chk("frame_parity", 32'(b[W+1]), 32'(^e));
`endif
            end
            exp_fc++;
            fc_pend = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    int  t0;
    bit  low;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_hold", st(), 32'h40000);
    end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("post_reset", st(), 32'h40000);

    // reset during data bit 3 of 0xFF
    buf_q.push_back(8'hFF);
    exp_q.push_back(8'hFF);
    @(posedge clk); #1 txEnable = 1'b1;
    wait_req(10, "req_ff");
    @(posedge clk); #1 txEnable = 1'b0;
    repeat (17) @(posedge clk);
    @(negedge clk);
    chk("ff_bit3", 32'({txd, busy}), 32'h3);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("mid_reset", st(), 32'h40000);

    // clean frame after reset, then empty-buffer retries
    buf_q.push_back(8'hA5);
    exp_q.push_back(8'hA5);
    @(posedge clk); #1 txEnable = 1'b1;
    wait_fc(1, 200, "fc_a5");
    chk("next_req", 32'(dataReadEnable), 32'd1);
    for (int k = 0; k < 3; k++) begin
      t0 = cyc;
      low = 1'b0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (!txd) low = 1'b1;
        if (dataReadEnable) break;
      end
      chk("retry_gap", 32'(cyc - t0), 32'd6);
      chk("retry_txd", 32'(low), 32'd0);
    end
    chk("fc_empty", 32'(frameCount), 32'd1);

    // word arrives while retrying
    buf_q.push_back(8'h3C);
    exp_q.push_back(8'h3C);
    wait_fc(2, 200, "fc_3c");
    @(posedge clk); #1 txEnable = 1'b0;
    repeat (10) @(negedge clk);
    chk("idle_after", st(), 32'h40002);

    // stale ack while disabled
    stale = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("stale", st(), 32'h40002);
    end
    @(posedge clk); #1 stale = 1'b0;

    buf_q.push_back(8'h81);
    exp_q.push_back(8'h81);
    @(posedge clk); #1 txEnable = 1'b1;
    wait_fc(3, 200, "fc_81");
    @(posedge clk); #1 txEnable = 1'b0;
    repeat (12) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("final", st(), 32'h40003);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

endmodule

// File: doc/ring_uart_tx.md
# ring_uart_tx

Serial transmitter that drains a ring buffer from its read side. It issues single-cycle read requests on the buffer's enable/ack read port and captures the returned word. It then shifts the word out LSB-first on an asynchronous-serial line (start bit, data, optional parity, stop bit). It sits between the ring buffer and the board TX pin, so that writers into the buffer need no knowledge of serial timing.

## Interface
Parameters:
- WordSize, 8, data width of the buffer read port and serial data bits per frame.
- ClocksPerBit, 16, clk cycles per serial bit; must be ≥ 2.
- RetryDelay, 4, idle cycles between a failed read request and the next request; must be ≥ 1.

Ports:
- clk  input  1  global clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- txEnable  input  1  when high, the block may fetch new words. When low, the current frame completes and no further request is issued.
- dataReadEnable  output  1  read request to the ring buffer; a single-cycle pulse.
- dataReadAck  input  1  buffer read success; valid in the cycle after a request.
- dataRead  input  WordSize  word returned by the buffer; valid with dataReadAck.
- txd  output  1  serial line, idle high.
- busy  output  1  high from the request cycle through the last stop-bit cycle.
- frameCount  output  16  frames fully transmitted; wraps modulo 2^16.

## Operation
- Reset values: txd=1, dataReadEnable=0, busy=0, frameCount=0, state IDLE, all counters 0.
- State IDLE: if txEnable=1, go to REQ.
- State REQ: assert dataReadEnable for exactly this cycle, set busy=1, then go to WAIT.
- State WAIT: dataReadEnable=0, and sample dataReadAck and dataRead.
  - If ack=1: latch dataRead into the shift register and go to START.
  - If ack=0 (buffer empty, or buffer busy with a write in the same cycle): go to BACKOFF.
- State BACKOFF: hold for RetryDelay cycles, with busy=0. Then go to REQ if txEnable=1, else to IDLE.
- State START: txd=0 for ClocksPerBit cycles.
- State DATA: shift WordSize bits LSB-first, ClocksPerBit cycles each.
- State PARITY: exists only when the macro is defined (see Configuration).
- State STOP: txd=1 for ClocksPerBit cycles. On the last cycle, increment frameCount. Then go to REQ if txEnable=1, else to IDLE.
- dataReadAck is sampled only in WAIT. A value held over from an earlier read is ignored in every other state.
- txEnable is sampled only in IDLE, BACKOFF exit, and STOP exit; it never aborts a frame.
- Reset asserted mid-frame: on the next edge, force the reset values. txd returns high immediately, the partial frame is lost, and no stop bit is completed.

## Timing
- Request at cycle N (REQ) → ack sampled at cycle N+1 (WAIT) → txd low from cycle N+2 when ack=1.
- Frame length without parity: (WordSize+2)×ClocksPerBit cycles.
- Back-to-back words: the next REQ is in the cycle after the last stop-bit cycle. The inter-frame gap is 2 cycles of txd high beyond the stop bit.
- Failed request: REQ, WAIT, then RetryDelay cycles, giving a retry period of RetryDelay+2 cycles.
- The bit counter and the clock divider reload at every state entry. There is no drift across bits.

## Configuration
- TX_PARITY_EN defined:
  - PARITY state is inserted after DATA.
  - txd carries even parity (XOR of the data bits) for ClocksPerBit cycles.
  - Frame length becomes (WordSize+3)×ClocksPerBit.
- TX_PARITY_EN undefined: the PARITY state and its logic are absent, and STOP follows DATA directly.

## Test plan
- Reset: hold reset 3 cycles → txd=1, dataReadEnable=0, busy=0, frameCount=0 throughout and on the first cycle after release.
- Single word (WordSize=8, ClocksPerBit=4, no parity): model returns ack=1 with 0xA5. txd shows 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 for 4 cycles. frameCount=1 and the next REQ follows immediately.
- Empty buffer (RetryDelay=4): model returns ack=0 → dataReadEnable pulses exactly every 6 cycles, txd stays 1, and frameCount is unchanged.
- Stale ack: hold dataReadAck=1 while txEnable=0 for 20 cycles → no request, no capture, and txd stays 1.
- Reset mid-frame: assert reset during data bit 3 of 0xFF → txd=1 on the next cycle, frameCount unchanged, and a new frame starts cleanly after release.
- Parity (TX_PARITY_EN defined): transmit 0x07 → parity bit 1 for ClocksPerBit cycles, and the frame is 11×ClocksPerBit cycles.
